// File: rtl/riscv_nn_rf_arb_pkg.sv
// Shared types and requester indices for the RF write-port arbiter.
// Output-stage register bundle and requester index constants.
package riscv_nn_rf_arb_pkg;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_NN  = 2;

  localparam int RF_ADDR_W = 6;
  localparam int RF_DATA_W = 32;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
    logic                 we;
  } rf_wport_t;

endpackage

// File: rtl/riscv_nn_rr_pick.sv
// Round-robin picker over requesters 1..N-1 starting at i_ptr.
// Returns first and second set bits of i_mask in that order, one-hot.
module riscv_nn_rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_mask,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_first,
  output logic [N-1:0]  o_second
);

  always_comb begin
    int hits;
    int idx;
    hits     = 0;
    idx      = 0;
    o_first  = '0;
    o_second = '0;
    for (int k = 0; k < N - 1; k++) begin
      idx = int'(i_ptr) + k;
      // slot 0 belongs to the priority requester, so wrap onto 1
      if (idx >= N) idx = idx - (N - 1);
      for (int j = 0; j < N; j++) begin
        if (j == idx && i_mask[j]) begin
          if (hits == 0) o_first[j] = 1'b1;
          else if (hits == 1) o_second[j] = 1'b1;
          hits = hits + 1;
        end
      end
    end
  end

endmodule

// File: rtl/riscv_nn_rf_wport_arbiter.sv
// Two-port register-file write arbiter with registered output stage.
// Define RF_WARB_AGING_EN to enable starvation aging of RR requesters.
module riscv_nn_rf_wport_arbiter
  import riscv_nn_rf_arb_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int ADDR_WIDTH = RF_ADDR_W,
  parameter int DATA_WIDTH = RF_DATA_W,
  parameter int STARVE_LIM = 8
) (
  input  logic                       clk_int,
  input  logic                       rst_n,
  input  logic                       rf_block_i,
  input  logic [NREQ-1:0]            req_valid_i,
  output logic [NREQ-1:0]            req_ready_o,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data_i,
  output logic [ADDR_WIDTH-1:0]      waddr_a_o,
  output logic [DATA_WIDTH-1:0]      wdata_a_o,
  output logic                       we_a_o,
  output logic [ADDR_WIDTH-1:0]      waddr_b_o,
  output logic [DATA_WIDTH-1:0]      wdata_b_o,
  output logic                       we_b_o,
  output logic [2**ADDR_WIDTH-1:0]   inflight_o
);

  localparam int PW = $clog2(NREQ);
  localparam logic [NREQ-1:0] RR_MASK = ~(NREQ'(1) << REQ_ALU);

  logic [ADDR_WIDTH-1:0] w_addr [NREQ];
  logic [DATA_WIDTH-1:0] w_data [NREQ];

  logic [NREQ-1:0] w_valid;
  logic [NREQ-1:0] w_rr_valid;
  logic [NREQ-1:0] w_gnt_a;
  logic [NREQ-1:0] w_gnt_b;
  logic [NREQ-1:0] w_conf;
  logic [NREQ-1:0] w_mask_b;
  logic [NREQ-1:0] w_rr_gnt;
  logic [NREQ-1:0] w_rr_first;
  logic [NREQ-1:0] w_b_first;
  logic [NREQ-1:0] w_l_first;
  logic [NREQ-1:0] w_l_second;
  logic [NREQ-1:0] w_last;
  logic [NREQ-1:0] w_unused_a2;
  logic [NREQ-1:0] w_unused_b2;

  logic [ADDR_WIDTH-1:0] w_addr_a;
  logic [ADDR_WIDTH-1:0] w_addr_b;
  logic [DATA_WIDTH-1:0] w_data_a;
  logic [DATA_WIDTH-1:0] w_data_b;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;

  rf_wport_t r_port_a;
  rf_wport_t r_port_b;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_addr[g] = req_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_data[g] = req_data_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign w_valid    = rf_block_i ? '0 : req_valid_i;
  assign w_rr_valid = w_valid & RR_MASK;

  riscv_nn_rr_pick #(.N(NREQ), .PW(PW)) u_pick_a (
    .i_mask   (w_rr_valid),
    .i_ptr    (r_ptr),
    .o_first  (w_rr_first),
    .o_second (w_unused_a2)
  );

`ifdef RF_WARB_AGING_EN
  localparam int CW = $clog2(STARVE_LIM + 1);

  logic [CW-1:0]   r_age [1:NREQ-1];
  logic [NREQ-1:0] w_starved;

  always_comb begin
    w_starved = '0;
    for (int i = 1; i < NREQ; i++)
      w_starved[i] = w_rr_valid[i] && (r_age[i] == CW'(STARVE_LIM));
  end

  // waiting is counted even while frozen; only a handshake clears
  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREQ; i++) r_age[i] <= '0;
    end else begin
      for (int i = 1; i < NREQ; i++) begin
        if (req_valid_i[i] && req_ready_o[i])
          r_age[i] <= '0;
        else if (req_valid_i[i] && r_age[i] != CW'(STARVE_LIM))
          r_age[i] <= r_age[i] + 1'b1;
      end
    end
  end
`endif

  always_comb begin
    w_gnt_a = '0;
    if (w_valid[REQ_ALU]) w_gnt_a[REQ_ALU] = 1'b1;
    else w_gnt_a = w_rr_first;
`ifdef RF_WARB_AGING_EN
    if (|w_starved) begin
      for (int i = NREQ - 1; i >= 1; i--) begin
        if (w_starved[i]) begin
          w_gnt_a    = '0;
          w_gnt_a[i] = 1'b1;
        end
      end
    end
`endif
  end

  always_comb begin
    w_addr_a = '0;
    w_data_a = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_a[i]) begin
        w_addr_a = w_addr[i];
        w_data_a = w_data[i];
      end
    end
  end

  always_comb begin
    w_conf = '0;
    for (int i = 0; i < NREQ; i++)
      w_conf[i] = (w_addr[i] == w_addr_a) && (w_addr_a != '0);
  end

  assign w_mask_b = w_rr_valid & ~w_gnt_a & ~w_conf;

  riscv_nn_rr_pick #(.N(NREQ), .PW(PW)) u_pick_b (
    .i_mask   (w_mask_b),
    .i_ptr    (r_ptr),
    .o_first  (w_b_first),
    .o_second (w_unused_b2)
  );

  always_comb begin
    w_gnt_b = w_b_first;
`ifdef RF_WARB_AGING_EN
    if (!w_gnt_a[REQ_ALU] && w_valid[REQ_ALU] && !w_conf[REQ_ALU]) begin
      w_gnt_b          = '0;
      w_gnt_b[REQ_ALU] = 1'b1;
    end
`endif
  end

  always_comb begin
    w_addr_b = '0;
    w_data_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_b[i]) begin
        w_addr_b = w_addr[i];
        w_data_b = w_data[i];
      end
    end
  end

  assign req_ready_o = w_gnt_a | w_gnt_b;
  assign w_rr_gnt    = req_ready_o & RR_MASK;

  // the later of the RR grantees in pointer order sets the next start
  riscv_nn_rr_pick #(.N(NREQ), .PW(PW)) u_pick_last (
    .i_mask   (w_rr_gnt),
    .i_ptr    (r_ptr),
    .o_first  (w_l_first),
    .o_second (w_l_second)
  );

  assign w_last = (|w_l_second) ? w_l_second : w_l_first;

  always_comb begin
    w_ptr_nxt = r_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (w_last[i])
        w_ptr_nxt = (i >= NREQ - 1) ? PW'(REQ_LSU) : PW'(i + 1);
    end
  end

  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      r_port_a <= '0;
      r_port_b <= '0;
      r_ptr    <= PW'(REQ_LSU);
    end else begin
      r_port_a.we <= (|w_gnt_a) && (w_addr_a != '0);
      r_port_b.we <= (|w_gnt_b) && (w_addr_b != '0);
      if (|w_gnt_a) begin
        r_port_a.addr <= w_addr_a;
        r_port_a.data <= w_data_a;
      end
      if (|w_gnt_b) begin
        r_port_b.addr <= w_addr_b;
        r_port_b.data <= w_data_b;
      end
      if (|w_rr_gnt) r_ptr <= w_ptr_nxt;
    end
  end

  assign waddr_a_o = r_port_a.addr;
  assign wdata_a_o = r_port_a.data;
  assign we_a_o    = r_port_a.we;
  assign waddr_b_o = r_port_b.addr;
  assign wdata_b_o = r_port_b.data;
  assign we_b_o    = r_port_b.we;

  always_comb begin
    inflight_o = '0;
    if (r_port_a.we) inflight_o[r_port_a.addr] = 1'b1;
    if (r_port_b.we) inflight_o[r_port_b.addr] = 1'b1;
  end

endmodule

// File: tb/tb_riscv_nn_rf_wport_arbiter.sv
// Directed bench for riscv_nn_rf_wport_arbiter with an output scoreboard.
// Honours RF_WARB_AGING_EN for the starvation scenario.
module tb_riscv_nn_rf_wport_arbiter;
  import riscv_nn_rf_arb_pkg::*;

`ifdef RF_WARB_AGING_EN
  localparam bit AGING = 1'b1;
`else
  localparam bit AGING = 1'b0;
`endif

  logic        clk_int = 1'b0;
  logic        rst_n;
  logic        rf_block_i;
  logic [2:0]  req_valid_i;
  logic [2:0]  req_ready_o;
  logic [17:0] req_addr_i;
  logic [95:0] req_data_i;
  logic [5:0]  waddr_a_o, waddr_b_o;
  logic [31:0] wdata_a_o, wdata_b_o;
  logic        we_a_o, we_b_o;
  logic [63:0] inflight_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_int = ~clk_int;

  riscv_nn_rf_wport_arbiter dut (
    .clk_int     (clk_int),
    .rst_n       (rst_n),
    .rf_block_i  (rf_block_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .waddr_a_o   (waddr_a_o),
    .wdata_a_o   (wdata_a_o),
    .we_a_o      (we_a_o),
    .waddr_b_o   (waddr_b_o),
    .wdata_b_o   (wdata_b_o),
    .we_b_o      (we_b_o),
    .inflight_o  (inflight_o)
  );

  typedef struct {
    logic        wa;
    logic [5:0]  aa;
    logic [31:0] da;
    logic        wb;
    logic [5:0]  ab;
    logic [31:0] db;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t E(input logic wa, input logic [5:0] aa,
                             input logic [31:0] da, input logic wb,
                             input logic [5:0] ab, input logic [31:0] db);
    exp_t r;
    r.wa = wa; r.aa = aa; r.da = da;
    r.wb = wb; r.ab = ab; r.db = db;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [2:0] v,
                     input logic [5:0] a0, input logic [31:0] d0,
                     input logic [5:0] a1, input logic [31:0] d1,
                     input logic [5:0] a2, input logic [31:0] d2,
                     input logic blk);
    req_valid_i = v;
    req_addr_i  = {a2, a1, a0};
    req_data_i  = {d2, d1, d0};
    rf_block_i  = blk;
  endtask

  task automatic step(input string tag, input logic [2:0] erdy, input exp_t e);
    exp_t x;
    logic [63:0] infl;
    sb.push_back(e);
    @(negedge clk_int);
    chk({tag, ".rdy"}, 64'(req_ready_o), 64'(erdy));
    @(posedge clk_int);
    #1;
    x    = sb.pop_front();
    infl = '0;
    if (x.wa) infl[x.aa] = 1'b1;
    if (x.wb) infl[x.ab] = 1'b1;
    chk({tag, ".we_a"}, 64'(we_a_o), 64'(x.wa));
    chk({tag, ".we_b"}, 64'(we_b_o), 64'(x.wb));
    if (x.wa) begin
      chk({tag, ".addr_a"}, 64'(waddr_a_o), 64'(x.aa));
      chk({tag, ".data_a"}, 64'(wdata_a_o), 64'(x.da));
    end
    if (x.wb) begin
      chk({tag, ".addr_b"}, 64'(waddr_b_o), 64'(x.ab));
      chk({tag, ".data_b"}, 64'(wdata_b_o), 64'(x.db));
    end
    chk({tag, ".inflight"}, inflight_o, infl);
  endtask

  initial begin
    exp_t none;
    none  = E(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    drv(3'b000, 0, 0, 0, 0, 0, 0, 1'b0);
    #12;
    chk("rst.we_a", 64'(we_a_o), 64'(0));
    chk("rst.we_b", 64'(we_b_o), 64'(0));
    chk("rst.addr_a", 64'(waddr_a_o), 64'(0));
    chk("rst.addr_b", 64'(waddr_b_o), 64'(0));
    chk("rst.data_a", 64'(wdata_a_o), 64'(0));
    chk("rst.data_b", 64'(wdata_b_o), 64'(0));
    chk("rst.inflight", inflight_o, 64'(0));
    chk("rst.rdy", 64'(req_ready_o), 64'(0));
    @(negedge clk_int);
    rst_n = 1'b1;
    @(posedge clk_int);
    #1;

    drv(3'b011, 5, 32'hA, 7, 32'hB, 0, 0, 1'b0);
    step("dual", 3'b011, E(1, 5, 32'hA, 1, 7, 32'hB));

    drv(3'b011, 9, 32'h1, 9, 32'h2, 0, 0, 1'b0);
    step("conf1", 3'b001, E(1, 9, 32'h1, 0, 0, 0));
    drv(3'b010, 0, 0, 9, 32'h2, 0, 0, 1'b0);
    step("conf2", 3'b010, E(1, 9, 32'h2, 0, 0, 0));
    drv(3'b000, 0, 0, 0, 0, 0, 0, 1'b0);
    step("idle1", 3'b000, none);

    drv(3'b110, 0, 0, 10, 32'h11, 11, 32'h22, 1'b0);
    step("rr2a", 3'b110, E(1, 11, 32'h22, 1, 10, 32'h11));
    drv(3'b110, 0, 0, 10, 32'h12, 11, 32'h23, 1'b0);
    step("rr2b", 3'b110, E(1, 11, 32'h23, 1, 10, 32'h12));

    drv(3'b111, 20, 32'h30, 10, 32'h13, 11, 32'h24, 1'b0);
    step("altb1", 3'b101, E(1, 20, 32'h30, 1, 11, 32'h24));
    drv(3'b111, 21, 32'h31, 10, 32'h13, 11, 32'h25, 1'b0);
    step("altb2", 3'b011, E(1, 21, 32'h31, 1, 10, 32'h13));
    drv(3'b111, 22, 32'h32, 10, 32'h14, 11, 32'h25, 1'b0);
    step("altb3", 3'b101, E(1, 22, 32'h32, 1, 11, 32'h25));

    drv(3'b010, 0, 0, 0, 32'hDEAD, 0, 0, 1'b0);
    step("x0", 3'b010, none);
    drv(3'b111, 1, 32'h1, 2, 32'h2, 3, 32'h3, 1'b1);
    step("block", 3'b000, none);
    drv(3'b110, 0, 0, 4, 32'h44, 12, 32'h55, 1'b0);
    step("unblk", 3'b110, E(1, 12, 32'h55, 1, 4, 32'h44));

    for (int k = 0; k < 9; k++) begin
      drv(3'b011, 3, 32'h100 + 32'(k), 3, 32'h77, 0, 0, 1'b0);
      if (AGING && k == 8)
        step("starve", 3'b010, E(1, 3, 32'h77, 0, 0, 0));
      else
        step("hold3", 3'b001, E(1, 3, 32'h100 + 32'(k), 0, 0, 0));
    end
    if (AGING) begin
      drv(3'b001, 3, 32'h200, 0, 0, 0, 0, 1'b0);
      step("after", 3'b001, E(1, 3, 32'h200, 0, 0, 0));
    end else begin
      drv(3'b010, 0, 0, 3, 32'h77, 0, 0, 1'b0);
      step("after", 3'b010, E(1, 3, 32'h77, 0, 0, 0));
    end

    drv(3'b001, 13, 32'hABC, 0, 0, 0, 0, 1'b0);
    @(posedge clk_int);
    #1;
    chk("arst.pre", 64'(we_a_o), 64'(1));
    drv(3'b000, 0, 0, 0, 0, 0, 0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst.we_a", 64'(we_a_o), 64'(0));
    chk("arst.addr_a", 64'(waddr_a_o), 64'(0));
    chk("arst.inflight", inflight_o, 64'(0));
    @(negedge clk_int);
    rst_n = 1'b1;
    @(posedge clk_int);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
